// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_ctrl (plus cpu_types_pkg)
// Description : Responder end of the cache-to-memory interface. Serialises
//               instruction-fetch and data requests from one CPU's caches
//               onto a single-ported, variable-latency RAM. Only one
//               transaction is in flight at a time.
//
// Ports       :
//   CLK, nRST              clock (rising edge), async active-low reset
//   iREN, iaddr            instruction read request / word address
//   iwait, iload           low for one cycle when iload holds fetched data
//   dREN, dWEN, daddr,     data read / write request, address, write data
//   dstore
//   dwait, dload           low for one cycle on read data valid / write done
//   ramREN, ramWEN,        RAM strobes, address and write data (registered)
//   ramaddr, ramstore
//   ramload, ramstate      RAM read data and FREE/BUSY/ACCESS/ERROR status
//   merr                   sticky: RAM errors exceeded RETRY_MAX on an access
//   icount, dcount,        (MEMCTRL_STATS_EN only) delivered instruction
//   errcount               responses, delivered data responses, RAM ERROR
//                          cycles; each 32 bits, wrapping
//
// Parameters  : CPUS (must be 1), RETRY_MAX (ERROR responses tolerated)
// Build macro : MEMCTRL_STATS_EN enables the statistics counters and ports
// Revision    : 1.0 - initial release
// ============================================================================

package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module mem_arbiter_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CPUS      = 1,
    parameter int RETRY_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
`ifdef MEMCTRL_STATS_EN
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] errcount,
`endif
    output logic        merr
);

    // Counter holds 0..RETRY_MAX; the access is abandoned on the error that
    // would push it past RETRY_MAX.
    localparam int                 c_CNT_W     = $clog2(RETRY_MAX + 2);
    localparam logic [c_CNT_W-1:0] c_RETRY_LIM = c_CNT_W'(RETRY_MAX);
    localparam logic [31:0]        c_ERR_LOAD  = 32'hBAD0_BAD0;

    generate
        if (CPUS != 1) begin : g_cpus_check
            $error("mem_arbiter_ctrl supports CPUS == 1 only");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IREAD  = 3'd1,
        S_DREAD  = 3'd2,
        S_DWRITE = 3'd3,
        S_IRESP  = 3'd4,
        S_DRESP  = 3'd5
    } state_t;

    state_t               state_q,    state_d;
    logic [31:0]          iload_q,    iload_d;
    logic [31:0]          dload_q,    dload_d;
    logic                 ramREN_q,   ramREN_d;
    logic                 ramWEN_q,   ramWEN_d;
    logic [31:0]          addr_q,     addr_d;
    logic [31:0]          wdata_q,    wdata_d;
    logic                 merr_q,     merr_d;
    logic [c_CNT_W-1:0]   retry_q,    retry_d;
    logic                 abort_q,    abort_d;
    logic                 prefer_i_q, prefer_i_d;
`ifdef MEMCTRL_STATS_EN
    logic [31:0]          icount_q,   icount_d;
    logic [31:0]          dcount_q,   dcount_d;
    logic [31:0]          errcount_q, errcount_d;
`endif

    logic                 w_live;
    logic                 w_in_access;
    logic                 w_give_up;
    logic                 w_done;
    logic [31:0]          w_load;

    always_comb begin
        state_d    = state_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        ramREN_d   = ramREN_q;
        ramWEN_d   = ramWEN_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merr_d     = merr_q;
        retry_d    = retry_q;
        abort_d    = abort_q;
        prefer_i_d = prefer_i_q;
        w_done     = 1'b0;
        w_load     = ramload;

        // A request is still "live" only while its enable is held and the
        // address it presents is the one latched at grant.
        case (state_q)
            S_IREAD:  w_live = iREN && (iaddr == addr_q);
            S_DREAD:  w_live = dREN && (daddr == addr_q);
            S_DWRITE: w_live = dWEN && (daddr == addr_q);
            default:  w_live = 1'b0;
        endcase

        w_in_access = (state_q == S_IREAD) || (state_q == S_DREAD) ||
                      (state_q == S_DWRITE);
        w_give_up   = (ramstate == ERROR) && (retry_q >= c_RETRY_LIM);

        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                abort_d = 1'b0;
                // One-shot alternation: right after a data response a pending
                // fetch wins even against a new data request.
                if (prefer_i_q && iREN) begin
                    state_d    = S_IREAD;
                    addr_d     = iaddr;
                    ramREN_d   = 1'b1;
                    prefer_i_d = 1'b0;
                end else if (dWEN) begin
                    state_d    = S_DWRITE;
                    addr_d     = daddr;
                    wdata_d    = dstore;
                    ramWEN_d   = 1'b1;
                    prefer_i_d = 1'b0;
                end else if (dREN) begin
                    state_d    = S_DREAD;
                    addr_d     = daddr;
                    ramREN_d   = 1'b1;
                    prefer_i_d = 1'b0;
                end else if (iREN) begin
                    state_d    = S_IREAD;
                    addr_d     = iaddr;
                    ramREN_d   = 1'b1;
                    prefer_i_d = 1'b0;
                end
            end
            S_IREAD, S_DREAD, S_DWRITE: begin
                if (!w_live) begin
                    abort_d = 1'b1;
                end
                if (ramstate == ACCESS) begin
                    w_done = 1'b1;
                end else if (ramstate == ERROR) begin
                    if (w_give_up) begin
                        merr_d = 1'b1;
                        w_done = 1'b1;
                        w_load = c_ERR_LOAD;
                    end else begin
                        // Strobe stays asserted, so the RAM sees the same
                        // access reissued on the next cycle.
                        retry_d = retry_q + c_CNT_W'(1);
                    end
                end
            end
            S_IRESP: begin
                state_d = S_IDLE;
                retry_d = '0;
            end
            S_DRESP: begin
                state_d    = S_IDLE;
                retry_d    = '0;
                prefer_i_d = iREN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_done) begin
            ramREN_d = 1'b0;
            ramWEN_d = 1'b0;
            retry_d  = '0;
            abort_d  = 1'b0;
            if (state_q == S_IREAD) begin
                iload_d = w_load;
            end
            if (state_q == S_DREAD) begin
                dload_d = w_load;
            end
            // A withdrawn request completes on the RAM but never pulses wait.
            if (abort_q || !w_live) begin
                state_d = S_IDLE;
            end else if (state_q == S_IREAD) begin
                state_d = S_IRESP;
            end else begin
                state_d = S_DRESP;
            end
        end

`ifdef MEMCTRL_STATS_EN
        icount_d   = icount_q   + {31'd0, (state_q == S_IRESP)};
        dcount_d   = dcount_q   + {31'd0, (state_q == S_DRESP)};
        errcount_d = errcount_q + {31'd0, (w_in_access && (ramstate == ERROR))};
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            iload_q    <= '0;
            dload_q    <= '0;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merr_q     <= 1'b0;
            retry_q    <= '0;
            abort_q    <= 1'b0;
            prefer_i_q <= 1'b0;
`ifdef MEMCTRL_STATS_EN
            icount_q   <= '0;
            dcount_q   <= '0;
            errcount_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            ramREN_q   <= ramREN_d;
            ramWEN_q   <= ramWEN_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            merr_q     <= merr_d;
            retry_q    <= retry_d;
            abort_q    <= abort_d;
            prefer_i_q <= prefer_i_d;
`ifdef MEMCTRL_STATS_EN
            icount_q   <= icount_d;
            dcount_q   <= dcount_d;
            errcount_q <= errcount_d;
`endif
        end
    end

    // Wait lines decode straight from state; only one RESP state exists at a
    // time, so the two can never be low together.
    assign iwait    = (state_q != S_IRESP);
    assign dwait    = (state_q != S_DRESP);
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ramREN_q;
    assign ramWEN   = ramWEN_q;
    assign ramaddr  = addr_q;
    assign ramstore = wdata_q;
    assign merr     = merr_q;
`ifdef MEMCTRL_STATS_EN
    assign icount   = icount_q;
    assign dcount   = dcount_q;
    assign errcount = errcount_q;
`endif

endmodule
`default_nettype wire

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Responder end of the cache-to-memory interface: services instruction-fetch requests (iREN/iaddr → iwait/iload) and data requests (dREN/dWEN/daddr/dstore → dwait/dload) from one CPU's caches.
- Serializes requests onto a single-ported RAM with variable latency.
- Sits between the icache/dcache and the RAM model; one transaction in flight at a time.

Parameters:
- CPUS, 1, number of CPUs; only 1 is supported; elaboration error otherwise.
- RETRY_MAX, 4, consecutive RAM ERROR responses tolerated per access before the error is reported.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request, level, held until served
- iaddr  in  32  instruction word address
- iwait  out  1  low for exactly one cycle when iload is valid; high otherwise
- iload  out  32  instruction data, valid only while iwait=0
- dREN  in  1  data read request
- dWEN  in  1  data write request; dREN&dWEN together is illegal
- daddr  in  32  data address
- dstore  in  32  write data
- dwait  out  1  low for exactly one cycle on read data valid or write complete
- dload  out  32  read data, valid while dwait=0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from cpu_types_pkg
- merr  out  1  sticky; set when RETRY_MAX is exceeded; cleared only by reset

Behaviour:
- Reset (async, nRST=0): state=IDLE; iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, merr=0, retry count=0.
- States: IDLE, IREAD, DREAD, DWRITE, IRESP, DRESP.
- IDLE, priority data over instruction:
  - dWEN → DWRITE; dREN → DREAD; else iREN → IREAD.
  - On grant, latch address and dstore into registers. ramaddr/ramstore drive from these registers, never combinationally from the cache ports.
- IREAD/DREAD/DWRITE:
  - Hold the matching RAM strobe high.
  - ramstate BUSY/FREE: stay.
  - ACCESS: capture ramload into iload/dload (reads only), drop strobe, go to IRESP/DRESP.
  - ERROR: increment retry count, reissue the same access next cycle.
  - Count > RETRY_MAX: set merr, then respond as ACCESS with load=32'hBAD0BAD0.
- IRESP/DRESP: drive iwait=0 / dwait=0 for exactly this one cycle, clear retry count, return to IDLE. Min latency request→wait-low = 3 cycles (grant, ACCESS, response).
- Request withdrawn mid-access (requesting REN/WEN low, or latched address ≠ current address):
  - Finish the RAM access, suppress the response pulse, return to IDLE.
  - iwait/dwait stay high throughout.
- iwait and dwait never go low in the same cycle; no wait pulse without a live matching request.
- Starvation bound: after a data response, if iREN is pending, the next grant goes to instruction even if a data request is present (one-shot alternation).
- Outputs are registered except iwait/dwait, which decode directly from state.

Optional Feature:
- MEMCTRL_STATS_EN:
  - Defined: adds outputs icount, dcount, errcount (32 bits each, wrap at 2^32). Each increments by 1 per delivered instruction response, delivered data response, and RAM ERROR cycle respectively. All reset to 0.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-DREAD (nRST low while ramstate=BUSY) → next cycle iwait=1, dwait=1, ramREN=0, merr=0, state IDLE.
- iREN=1, iaddr=0x40; RAM BUSY 2 cycles then ACCESS with ramload=0x8C220004 → ramaddr=0x40, exactly one cycle iwait=0 with iload=0x8C220004, then iwait=1.
- iREN and dWEN (daddr=0x100, dstore=0xDEADBEEF) raised together → write granted first (ramWEN=1, ramstore=0xDEADBEEF), dwait pulse; instruction served next; iwait pulse 3+ cycles later.
- Continuous dREN plus iREN → grants alternate D, I, D, I; no iwait/dwait overlap.
- iREN dropped after grant while RAM BUSY → no iwait pulse; controller back in IDLE after ACCESS.
- RAM returns ERROR 5 times with RETRY_MAX=4 → merr=1, dwait pulse with dload=0xBAD0BAD0; with MEMCTRL_STATS_EN, errcount=5 and dcount=1.
